// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// decode_queue_if
//   Groups the decode-queue handshake signals between the front-end decoder,
//   the back-end rename stage and the queue itself.
//   Signal names keep their block-level port names so they trace directly to
//   the be_top connections.
//
//   Modports
//     master : environment side (decoder + back-end); drives data, valid,
//              rename ready and mispredict.
//     slave  : queue side; drives ready, head entry, head valid, occupancy
//              and almost-full.
// -----------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] dec_data_i;
  logic                  dec_v_i;
  logic                  dec_ready_o;
  logic                  mispredict_i;
  logic [DATA_WIDTH-1:0] decoded_o;
  logic                  decoded_v_o;
  logic                  rename_ready_i;
  logic [CNT_W-1:0]      count_o;
  logic                  almost_full_o;

  modport master (
    output dec_data_i, dec_v_i, mispredict_i, rename_ready_i,
    input  dec_ready_o, decoded_o, decoded_v_o, count_o, almost_full_o
  );

  modport slave (
    input  dec_data_i, dec_v_i, mispredict_i, rename_ready_i,
    output dec_ready_o, decoded_o, decoded_v_o, count_o, almost_full_o
  );
endinterface

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//   Decoupling FIFO between front-end decode and back-end rename. Buffers
//   decoded instructions with valid/ready on both sides and discards every
//   wrong-path entry in a single cycle when the back-end signals a mispredict.
//
//   Ports
//     clk_i    : clock, rising edge
//     reset_i  : asynchronous, active-high reset
//     bus      : decode_queue_if.slave
//                 dec_data_i/dec_v_i/dec_ready_o     decoder push handshake
//                 decoded_o/decoded_v_o/rename_ready_i rename pop handshake
//                 mispredict_i                       one-cycle flush request
//                 count_o                            registered occupancy
//                 almost_full_o                      registered fetch throttle
//
//   Head entry is visible the cycle after it is pushed; there is no bypass
//   from dec_data_i to decoded_o on an empty queue.
// -----------------------------------------------------------------------------
module decode_queue #(
  parameter int DATA_WIDTH = 32,   // DECODED_INSTRUCTION_WIDTH in the core
  parameter int DEPTH      = 8,    // power of 2, >= 2
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  decode_queue_if.slave     bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;   // MSB is the wrap bit

  localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             almost_full;

  logic full, empty, push, pop;

  // Ready depends only on the registered count, so the decoder never sees
  // a combinational path from rename_ready_i.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign bus.dec_ready_o = !full;

  // The head is withheld during a flush cycle so rename never accepts a
  // wrong-path instruction.
  assign bus.decoded_v_o = !empty && !bus.mispredict_i;
  assign bus.decoded_o   = mem[rd_ptr[IDX_W-1:0]];

  assign push = bus.dec_v_i && !full && !bus.mispredict_i;
  assign pop  = bus.decoded_v_o && bus.rename_ready_i;

  assign bus.count_o       = count;
  assign bus.almost_full_o = almost_full;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (bus.mispredict_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;  // idle, or push+pop cancel out
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AFULL_CNT);
    end
  end

  // NOTE: storage is deliberately left out of reset; valid tracking comes
  // from the pointers, and an un-reset array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= bus.dec_data_i;
  end

  // Structural invariants of the queue.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(push && full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(pop && empty));
  a_count_ptrs   : assert property (@(posedge clk_i) disable iff (reset_i)
                                    count == PTR_W'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//   Directed self-checking bench for decode_queue (DEPTH=8, 8-bit data).
//   Inputs change 1ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_decode_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk_i;
  logic reset_i;

  decode_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  decode_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(DEPTH - 2)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bus.dec_data_i = d;
    bus.dec_v_i    = 1'b1;
    step();
    bus.dec_v_i    = 1'b0;
  endtask

  // Bounded overall run time: abort with a FAIL line if something stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.dec_data_i     = '0;
    bus.dec_v_i        = 1'b0;
    bus.mispredict_i   = 1'b0;
    bus.rename_ready_i = 1'b0;
    reset_i            = 1'b1;

    // 1 Reset
    repeat (3) step();
    check("rst_valid", 32'(bus.decoded_v_o), 32'd0);
    check("rst_ready", 32'(bus.dec_ready_o), 32'd1);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_afull", 32'(bus.almost_full_o), 32'd0);
    reset_i = 1'b0;
    step();

    // 2 Fill with rename stalled
    for (int i = 1; i <= DEPTH; i++) begin
      push_one(DW'(i));
      check($sformatf("fill_count%0d", i), 32'(bus.count_o), 32'(i));
      check($sformatf("fill_afull%0d", i), 32'(bus.almost_full_o), (i >= 6) ? 32'd1 : 32'd0);
      check($sformatf("fill_ready%0d", i), 32'(bus.dec_ready_o), (i < DEPTH) ? 32'd1 : 32'd0);
    end
    push_one(8'h09);  // ignored: queue full
    check("full_count", 32'(bus.count_o), 32'd8);
    check("full_head",  32'(bus.decoded_o), 32'h01);

    // 3 Drain in order
    bus.rename_ready_i = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain_v%0d", i), 32'(bus.decoded_v_o), 32'd1);
      check($sformatf("drain_d%0d", i), 32'(bus.decoded_o), 32'(i));
      step();
    end
    check("drain_v_end",  32'(bus.decoded_v_o), 32'd0);
    check("drain_count",  32'(bus.count_o), 32'd0);
    check("drain_afull",  32'(bus.almost_full_o), 32'd0);
    check("drain_ready",  32'(bus.dec_ready_o), 32'd1);

    // 4 Streaming across the pointer wrap, 3 entries resident
    bus.rename_ready_i = 1'b0;
    push_one(8'h10);
    push_one(8'h11);
    push_one(8'h12);
    check("stream_pre_count", 32'(bus.count_o), 32'd3);
    bus.rename_ready_i = 1'b1;
    bus.dec_v_i        = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.dec_data_i = DW'(8'h13 + k);
      check($sformatf("stream_d%0d", k), 32'(bus.decoded_o), 32'(8'h10 + k));
      step();
      check($sformatf("stream_cnt%0d", k), 32'(bus.count_o), 32'd3);
    end
    bus.dec_v_i        = 1'b0;
    bus.rename_ready_i = 1'b0;
    check("stream_head_after", 32'(bus.decoded_o), 32'h24);

    // 5 Flush with 5 entries and a concurrent push
    push_one(8'h27);
    push_one(8'h28);
    check("flush_pre_count", 32'(bus.count_o), 32'd5);
    bus.mispredict_i   = 1'b1;
    bus.dec_v_i        = 1'b1;
    bus.dec_data_i     = 8'h55;
    bus.rename_ready_i = 1'b1;
    #1;
    check("flush_v_same_cycle", 32'(bus.decoded_v_o), 32'd0);
    step();
    bus.mispredict_i   = 1'b0;
    bus.dec_v_i        = 1'b0;
    bus.rename_ready_i = 1'b0;
    check("flush_count", 32'(bus.count_o), 32'd0);
    check("flush_v",     32'(bus.decoded_v_o), 32'd0);
    check("flush_ready", 32'(bus.dec_ready_o), 32'd1);
    check("flush_afull", 32'(bus.almost_full_o), 32'd0);
    bus.dec_data_i = 8'hAA;
    bus.dec_v_i    = 1'b1;
    #1;
    check("post_flush_no_bypass", 32'(bus.decoded_v_o), 32'd0);
    step();
    bus.dec_v_i = 1'b0;
    check("post_flush_v",     32'(bus.decoded_v_o), 32'd1);
    check("post_flush_data",  32'(bus.decoded_o), 32'hAA);
    check("post_flush_count", 32'(bus.count_o), 32'd1);

    // Back-to-back mispredicts with pushes attempted keep the queue empty
    bus.mispredict_i = 1'b1;
    bus.dec_v_i      = 1'b1;
    bus.dec_data_i   = 8'h66;
    step();
    step();
    check("b2b_count", 32'(bus.count_o), 32'd0);
    bus.mispredict_i = 1'b0;
    bus.dec_v_i      = 1'b0;
    #1;
    check("b2b_v", 32'(bus.decoded_v_o), 32'd0);

    // 6 Async reset mid-stream, between clock edges
    push_one(8'h31);
    push_one(8'h32);
    push_one(8'h33);
    push_one(8'h34);
    check("areset_pre_count", 32'(bus.count_o), 32'd4);
    #1;
    reset_i = 1'b1;
    #1;
    check("areset_count", 32'(bus.count_o), 32'd0);
    check("areset_v",     32'(bus.decoded_v_o), 32'd0);
    check("areset_ready", 32'(bus.dec_ready_o), 32'd1);
    step();
    reset_i = 1'b0;
    step();
    check("areset_hold_count", 32'(bus.count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
